// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between NREQ requesters, the arbiter and the shared FIFO.
// master: requester/FIFO side that drives requests, data and the full flag.
// slave : the arbiter, which returns grants and drives the FIFO write port.
interface fifo_wr_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 8
);
    logic [NREQ-1:0]    req_i;
    logic [NREQ*DW-1:0] data_i;
    logic [NREQ-1:0]    gnt_o;
    logic               fifo_full_i;
    logic               fifo_wr_en_o;
    logic [DW-1:0]      fifo_data_o;
    logic               busy_o;

    modport master (
        output req_i, data_i, fifo_full_i,
        input  gnt_o, fifo_wr_en_o, fifo_data_o, busy_o
    );

    modport slave (
        input  req_i, data_i, fifo_full_i,
        output gnt_o, fifo_wr_en_o, fifo_data_o, busy_o
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that merges NREQ write requesters into one shared FIFO.
// The grant is combinational (zero latency) and gated by fifo_full_i/reset_i,
// so a beat is accepted exactly in the cycle its gnt_o bit is high.
// Optional burst locking is enabled by defining FIFO_WR_ARBITER_BURST_EN: the
// first granted requester then keeps the port for up to BURST_LEN beats.
module fifo_wr_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DW        = 8,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    fifo_wr_arbiter_if.slave bus
);
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr;
    logic [NREQ-1:0] elig_c;
    logic [NREQ-1:0] gnt_c;
    logic [PW-1:0]   win_c;
    logic            found_c;
    logic [DW-1:0]   data_c;

    // (base + off) mod NREQ, valid for non-power-of-two NREQ
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int unsigned off);
        return PW'((32'(base) + off) % NREQ);
    endfunction

`ifdef FIFO_WR_ARBITER_BURST_EN
    localparam int unsigned CW = $clog2(BURST_LEN + 1);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t        state;
    logic [PW-1:0] owner;
    logic [CW-1:0] count;

    // While locked only the burst owner may compete
    assign elig_c = (state == LOCK) ? (bus.req_i & (NREQ'(1) << owner)) : bus.req_i;

    // Burst lock FSM and rotation pointer; pointer moves past the owner on unlock
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
            owner <= '0;
            count <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|gnt_c) begin
                        if (BURST_LEN <= 1) begin
                            ptr <= wrap_add(win_c, 1);
                        end else begin
                            state <= LOCK;
                            owner <= win_c;
                            count <= CW'(1);
                        end
                    end
                end
                LOCK: begin
                    if (!bus.req_i[owner]) begin
                        state <= IDLE;
                        count <= '0;
                        ptr   <= wrap_add(owner, 1);
                    end else if (|gnt_c) begin
                        if (32'(count) + 32'd1 >= BURST_LEN) begin
                            state <= IDLE;
                            count <= '0;
                            ptr   <= wrap_add(owner, 1);
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy_o = !reset_i && ((|bus.req_i) || (state == LOCK));
`else
    assign elig_c = bus.req_i;

    // Rotation pointer: one past the last accepted requester
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr <= '0;
        end else if (|gnt_c) begin
            ptr <= wrap_add(win_c, 1);
        end
    end

    assign bus.busy_o = !reset_i && (|bus.req_i);
`endif

    // First eligible requester searching upward from ptr with wrap
    always_comb begin
        found_c = 1'b0;
        win_c   = '0;
        gnt_c   = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            if (!found_c && elig_c[wrap_add(ptr, off)]) begin
                found_c = 1'b1;
                win_c   = wrap_add(ptr, off);
            end
        end
        if (found_c && !bus.fifo_full_i && !reset_i) begin
            gnt_c[win_c] = 1'b1;
        end
    end

    // AND-OR mux of the granted beat; zero when nothing is granted
    always_comb begin
        data_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_c[i]) begin
                data_c = data_c | bus.data_i[i*DW +: DW];
            end
        end
    end

    assign bus.gnt_o        = gnt_c;
    assign bus.fifo_wr_en_o = |gnt_c;
    assign bus.fifo_data_o  = data_c;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a driver pushes the expected response
// of every cycle, a negedge monitor pops and compares against the DUT.
// Expectations come from fixed grant tables for the directed cases and from a
// behavioural round-robin/burst model for the randomised phase.
module tb_fifo_wr_arbiter;
    localparam int NREQ      = 4;
    localparam int DW        = 8;
    localparam int BURST_LEN = 4;

    logic clk = 1'b0;
    logic reset;

    fifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

    fifo_wr_arbiter #(
        .NREQ(NREQ),
        .DW(DW),
        .BURST_LEN(BURST_LEN)
    ) dut (
        .clk_i(clk),
        .reset_i(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0] gnt;
        logic [DW-1:0]   data;
        logic            busy;
    } exp_t;

    exp_t          exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    bit            mon_en   = 1'b0;
    logic [DW-1:0] drv_data [NREQ];

    // Reference model state
    int m_ptr   = 0;
    int m_owner = 0;
    int m_count = 0;
    bit m_lock  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of the arbitration rules: predicts grant/busy, then advances state
    task automatic model_step(input logic [NREQ-1:0] req, input logic full, input logic rst,
                              output logic [NREQ-1:0] g, output logic busy);
        int win;
        int k;
        g    = '0;
        busy = 1'b0;
        win  = -1;
        if (rst) begin
            m_ptr   = 0;
            m_lock  = 1'b0;
            m_count = 0;
            m_owner = 0;
            return;
        end
        busy = (req != '0) || m_lock;
        if (!full) begin
            for (int s = 0; s < NREQ; s++) begin
                k = (m_ptr + s) % NREQ;
                if (win < 0 && req[k] && (!m_lock || k == m_owner)) win = k;
            end
            if (win >= 0) g[win] = 1'b1;
        end
`ifdef FIFO_WR_ARBITER_BURST_EN
        if (m_lock) begin
            if (!req[m_owner]) begin
                m_lock = 1'b0;
                m_ptr  = (m_owner + 1) % NREQ;
            end else if (win >= 0) begin
                m_count++;
                if (m_count >= BURST_LEN) begin
                    m_lock = 1'b0;
                    m_ptr  = (m_owner + 1) % NREQ;
                end
            end
        end else if (win >= 0) begin
            if (BURST_LEN <= 1) begin
                m_ptr = (win + 1) % NREQ;
            end else begin
                m_lock  = 1'b1;
                m_owner = win;
                m_count = 1;
            end
        end
`else
        if (win >= 0) m_ptr = (win + 1) % NREQ;
`endif
    endtask

    // Drive one cycle and push its expected outputs (table grant if use_tab)
    task automatic step(input logic [NREQ-1:0] req, input logic full, input logic rst,
                        input bit use_tab, input logic [NREQ-1:0] tab,
                        output logic [NREQ-1:0] g);
        logic b;
        exp_t e;
        @(posedge clk);
        #1;
        reset           = rst;
        bus.req_i       = req;
        bus.fifo_full_i = full;
        for (int i = 0; i < NREQ; i++) bus.data_i[i*DW +: DW] = drv_data[i];
        model_step(req, full, rst, g, b);
        e.gnt  = use_tab ? tab : g;
        e.busy = b;
        e.data = '0;
        for (int i = 0; i < NREQ; i++) if (e.gnt[i]) e.data = drv_data[i];
        exp_q.push_back(e);
        mon_en = 1'b1;
    endtask

    // Monitor: invariants every cycle plus scoreboard comparison
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            chk("gnt_onehot0", 32'($onehot0(bus.gnt_o)), 32'd1);
            chk("wr_en_while_full", 32'(bus.fifo_wr_en_o & bus.fifo_full_i), 32'd0);
            chk("exp_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("gnt", 32'(bus.gnt_o), 32'(e.gnt));
                chk("wr_en", 32'(bus.fifo_wr_en_o), 32'(|e.gnt));
                chk("data", 32'(bus.fifo_data_o), 32'(e.data));
                chk("busy", 32'(bus.busy_o), 32'(e.busy));
            end
        end
    end

    initial begin
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] t;
        logic [NREQ-1:0] req;
        logic            full;
        logic            rst;
        bit              pend [NREQ];

        reset           = 1'b1;
        bus.req_i       = '0;
        bus.data_i      = '0;
        bus.fifo_full_i = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            drv_data[i] = DW'(32'h30 + 17 * i);
            pend[i]     = 1'b0;
        end

        step(4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, g);
        step(4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, g);

        // All requesting: strict rotation, or 4-beat bursts with two requesters
`ifdef FIFO_WR_ARBITER_BURST_EN
        for (int c = 0; c < 12; c++) begin
            t = (c < 4) ? 4'b0001 : (c < 8) ? 4'b0010 : 4'b0001;
            step(4'b0011, 1'b0, 1'b0, 1'b1, t, g);
        end
`else
        for (int c = 0; c < 8; c++) begin
            t = 4'b0001 << (c % 4);
            step(4'b1111, 1'b0, 1'b0, 1'b1, t, g);
        end
`endif

        // Requesters 1 and 3 only
        step(4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, g);
`ifdef FIFO_WR_ARBITER_BURST_EN
        for (int c = 0; c < 8; c++) begin
            t = (c < 4) ? 4'b0010 : 4'b1000;
            step(4'b1010, 1'b0, 1'b0, 1'b1, t, g);
        end
`else
        for (int c = 0; c < 6; c++) begin
            t = (c % 2 == 0) ? 4'b0010 : 4'b1000;
            step(4'b1010, 1'b0, 1'b0, 1'b1, t, g);
        end
`endif

        // FIFO full holds off the grant, data unchanged afterwards
        step(4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, g);
        for (int c = 0; c < 3; c++) step(4'b0001, 1'b1, 1'b0, 1'b1, 4'b0000, g);
        step(4'b0001, 1'b0, 1'b0, 1'b1, 4'b0001, g);

        // Reset in the middle of requester 2's run; restart from index 0
        step(4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, g);
        step(4'b0100, 1'b0, 1'b0, 1'b1, 4'b0100, g);
        step(4'b0100, 1'b0, 1'b0, 1'b1, 4'b0100, g);
        step(4'b0111, 1'b0, 1'b1, 1'b1, 4'b0000, g);
        step(4'b0111, 1'b0, 1'b0, 1'b1, 4'b0001, g);

        // Randomised traffic against the model
        step(4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, g);
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NREQ; i++) req[i] = pend[i];
            full = ($urandom_range(3) == 0);
            rst  = ($urandom_range(499) == 0);
            step(req, full, rst, 1'b0, 4'b0000, g);
            for (int i = 0; i < NREQ; i++) begin
                if (g[i]) pend[i] = 1'b0;
                if (!pend[i]) begin
                    if ($urandom_range(3) != 0) begin
                        pend[i]     = 1'b1;
                        drv_data[i] = DW'($urandom);
                    end
                end else if ($urandom_range(15) == 0) begin
                    pend[i] = 1'b0;
                end
            end
        end
        step(4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, g);

        @(negedge clk);
        #1;
        mon_en = 1'b0;
        chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of write requesters (2..8).
REQ-002 Parameter DW, default 8, data width of each requester and of the FIFO write port.
REQ-003 Parameter BURST_LEN, default 4, maximum consecutive beats one requester may hold (used only with the Configuration feature).
REQ-004 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-005 reset_i  input  1  synchronous, active-high reset.
REQ-006 req_i  input  NREQ  bit i high = requester i has a beat to write; held with data until granted.
REQ-007 data_i  input  NREQ*DW  packed beat data, requester i in bits [i*DW +: DW].
REQ-008 gnt_o  output  NREQ  one-hot (or zero) grant; gnt_o[i]=1 = requester i's beat is accepted this cycle.
REQ-009 fifo_full_i  input  1  full flag from the shared FIFO.
REQ-010 fifo_wr_en_o  output  1  write enable to the shared FIFO.
REQ-011 fifo_data_o  output  DW  write data to the shared FIFO.
REQ-012 busy_o  output  1  high while any req_i bit is high or a burst lock is held.

Function
REQ-013 gnt_o SHALL be combinational from req_i, fifo_full_i, priority pointer and lock state, with zero-cycle latency; at most one bit high.
REQ-014 gnt_o SHALL be all-zero whenever fifo_full_i=1 or reset_i=1; no beat is lost or duplicated.
REQ-015 fifo_wr_en_o SHALL equal OR of gnt_o; fifo_data_o SHALL equal the granted requester's data, else all-zero.
REQ-016 Round-robin: the winner is the first requester with req_i high searching upward from pointer ptr, wrapping NREQ-1 -> 0.
REQ-017 After each accepted beat by requester k (no lock), ptr SHALL become (k+1) mod NREQ at the next edge; ptr unchanged on cycles with no grant.
REQ-018 A requester deasserting req_i while not granted SHALL not affect ptr.
REQ-019 Fairness: with all requests continuously high and FIFO never full, each requester SHALL receive exactly one beat in every NREQ consecutive beats.
REQ-020 busy_o SHALL be registered-free (combinational) per REQ-012.

Reset
REQ-021 While reset_i=1 at an edge: ptr=0, lock cleared, burst counter=0.
REQ-022 During reset_i=1: gnt_o=0, fifo_wr_en_o=0, fifo_data_o=0, busy_o=0.
REQ-023 Reset asserted mid-burst SHALL abort the burst; first post-reset grant follows ptr=0 priority.

Configuration
REQ-024 Macro FIFO_WR_ARBITER_BURST_EN SHALL select burst locking.
REQ-025 With the macro defined: a two-state FSM IDLE/LOCK; first accepted beat by requester k enters LOCK (owner=k, count=1).
REQ-026 In LOCK: only owner may be granted; each accepted beat increments count; FIFO-full cycles hold state and count.
REQ-027 LOCK -> IDLE when owner deasserts req_i or count reaches BURST_LEN; on exit ptr=(owner+1) mod NREQ.
REQ-028 Without the macro: no FSM, no counter; rotation per REQ-017 after every beat; BURST_LEN unused.

Verification
REQ-029 req_i=4'b1111, full=0, 8 cycles -> gnt_o sequence 0001,0010,0100,1000,0001,0010,0100,1000 (macro undefined).
REQ-030 req_i=4'b1010, full=0 from reset -> gnt 0010 then 1000 alternating; data_o matches data_i slices 1,3.
REQ-031 req_i=4'b0001, fifo_full_i=1 for 3 cycles then 0 -> gnt_o=0, wr_en=0 for 3 cycles, then gnt_o=0001 with unchanged data.
REQ-032 Macro defined, BURST_LEN=4, req_i=4'b0011 held -> gnt 0001 x4, then 0010 x4, then 0001 x4.
REQ-033 Macro defined, reset_i=1 after 2 beats of requester 2's burst -> outputs zero that cycle; next grant goes to lowest active requester from index 0.
REQ-034 Randomised req_i and fifo_full_i, 10000 cycles -> never more than one gnt bit, never wr_en with full=1, scoreboard per-requester order preserved.
